pwm_compare_deadtime: RTL and testbench

PWM_COMPARE_DEADTIME -- requirements
Module: pwm_compare_deadtime

---
 rtl/pwm_compare_deadtime.sv | 193 +++++++++++++++++++
 tb/tb_pwm_compare_deadtime.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_compare_deadtime.sv
// Purpose: three-leg PWM compare with per-leg dead-time insertion and fault gating.
// Latency: gates follow triangle_count by 2 clk; each commutation adds DEAD_TIME clk of both-off.
// Backpressure: none; duty_valid/new_cycle are fire-and-forget strobes, never stalled.
//
// Ports:
//   clk, reset          : 40 MHz clock, asynchronous active-high reset
//   enable              : synchronous run enable (low = all gates off, compares cleared)
//   new_cycle           : carrier valley strobe, loads the active compare set
//   triangle_count      : carrier value 0..8000
//   duty_a/b/c          : compare references, captured on duty_valid
//   fault, fault_clear  : protection trip and acknowledge
//   gate_xh / gate_xl   : registered high/low-side gate commands per leg
//   cycle_loaded        : one-cycle pulse when the compare set is loaded
//   tripped             : fault state
// Build option: define PWM_FAULT_LATCH_EN to latch faults until fault_clear;
// otherwise tripped is a registered copy of fault.
module pwm_compare_deadtime #(
  parameter logic [15:0] DUTY_MAX  = 16'd8001,
  parameter int unsigned DEAD_TIME = 80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        new_cycle,
  input  logic [15:0] triangle_count,
  input  logic [15:0] duty_a,
  input  logic [15:0] duty_b,
  input  logic [15:0] duty_c,
  input  logic        duty_valid,
  input  logic        fault,
  input  logic        fault_clear,
  output logic        gate_ah,
  output logic        gate_al,
  output logic        gate_bh,
  output logic        gate_bl,
  output logic        gate_ch,
  output logic        gate_cl,
  output logic        cycle_loaded,
  output logic        tripped
);

  localparam int unsigned CW = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEAD_TIME - 1);

  typedef enum logic [1:0] {
    S_DEAD = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } leg_state_t;

  logic [15:0] duty_in [3];
  logic [15:0] pending [3];
  logic [15:0] cmp     [3];
  logic [2:0]  raw;
  logic        halt;

  assign duty_in[0] = duty_a;
  assign duty_in[1] = duty_b;
  assign duty_in[2] = duty_c;

  function automatic logic [15:0] sat(input logic [15:0] d);
    return (d >= DUTY_MAX) ? DUTY_MAX : d;
  endfunction

  // fault is included directly so gates drop on the same edge that sets tripped.
  assign halt = !enable || tripped || fault;

  // Duty capture, compare-set load and carrier compare.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        pending[i] <= '0;
        cmp[i]     <= '0;
      end
      raw          <= '0;
      cycle_loaded <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        // pending keeps tracking duty_valid even while disabled
        if (duty_valid)
          pending[i] <= sat(duty_in[i]);
        if (!enable)
          cmp[i] <= '0;
        else if (new_cycle)
          // a coincident strobe bypasses pending so a stale value is never applied
          cmp[i] <= duty_valid ? sat(duty_in[i]) : pending[i];
        raw[i] <= (triangle_count < cmp[i]);
      end
      cycle_loaded <= enable && new_cycle;
    end
  end

  // Fault state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tripped <= 1'b0;
    end else begin
`ifdef PWM_FAULT_LATCH_EN
      if (fault)
        tripped <= 1'b1;
      else if (fault_clear)
        tripped <= 1'b0;
`else
      tripped <= fault;
`endif
    end
  end

`ifndef PWM_FAULT_LATCH_EN
  logic unused_fault_clear;
  assign unused_fault_clear = fault_clear;
`endif

  // Per-leg dead-time FSM. Gate registers are written together with the
  // state so they always reflect the state being entered.
  for (genvar g = 0; g < 3; g++) begin : g_leg
    leg_state_t    state;
    logic [CW-1:0] cnt;
    logic          raw_d;
    logic          gh;
    logic          gl;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state <= S_DEAD;
        cnt   <= '0;
        raw_d <= 1'b0;
        gh    <= 1'b0;
        gl    <= 1'b0;
      end else begin
        raw_d <= raw[g];
        if (halt) begin
          state <= S_DEAD;
          cnt   <= '0;
          gh    <= 1'b0;
          gl    <= 1'b0;
        end else begin
          case (state)
            S_HIGH: begin
              if (!raw[g]) begin
                state <= S_DEAD;
                cnt   <= '0;
                gh    <= 1'b0;
                gl    <= 1'b0;
              end else begin
                gh <= 1'b1;
                gl <= 1'b0;
              end
            end
            S_LOW: begin
              if (raw[g]) begin
                state <= S_DEAD;
                cnt   <= '0;
                gh    <= 1'b0;
                gl    <= 1'b0;
              end else begin
                gh <= 1'b0;
                gl <= 1'b1;
              end
            end
            default: begin
              gh <= 1'b0;
              gl <= 1'b0;
              // any movement of raw restarts the dead interval
              if (raw[g] != raw_d) begin
                cnt <= '0;
              end else if (cnt == CNT_LAST) begin
                cnt <= '0;
                if (raw[g]) begin
                  state <= S_HIGH;
                  gh    <= 1'b1;
                end else begin
                  state <= S_LOW;
                  gl    <= 1'b1;
                end
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          endcase
        end
      end
    end
  end

  assign gate_ah = g_leg[0].gh;
  assign gate_al = g_leg[0].gl;
  assign gate_bh = g_leg[1].gh;
  assign gate_bl = g_leg[1].gl;
  assign gate_ch = g_leg[2].gh;
  assign gate_cl = g_leg[2].gl;

endmodule

// File: tb/tb_pwm_compare_deadtime.sv
// Bench for pwm_compare_deadtime: directed carrier/duty/fault/reset vectors.
// Expected output snapshots are queued with their due cycle; a negedge monitor
// pops and compares them against the observed output vector.
module tb_pwm_compare_deadtime;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        new_cycle;
  logic [15:0] triangle_count;
  logic [15:0] duty_a, duty_b, duty_c;
  logic        duty_valid;
  logic        fault, fault_clear;
  logic        gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl;
  logic        cycle_loaded, tripped;

  pwm_compare_deadtime #(.DUTY_MAX(16'd8001), .DEAD_TIME(80)) dut (
    .clk(clk), .reset(reset), .enable(enable), .new_cycle(new_cycle),
    .triangle_count(triangle_count), .duty_a(duty_a), .duty_b(duty_b),
    .duty_c(duty_c), .duty_valid(duty_valid), .fault(fault),
    .fault_clear(fault_clear), .gate_ah(gate_ah), .gate_al(gate_al),
    .gate_bh(gate_bh), .gate_bl(gate_bl), .gate_ch(gate_ch), .gate_cl(gate_cl),
    .cycle_loaded(cycle_loaded), .tripped(tripped)
  );

  // observed vector: {tripped, cycle_loaded, ah, al, bh, bl, ch, cl}
  logic [7:0] obs;
  assign obs = {tripped, cycle_loaded, gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl};

  localparam logic [7:0] M_ALL = 8'hFF;
  localparam logic [7:0] M_G   = 8'h3F;
  localparam logic [7:0] M_A   = 8'h30;
  localparam logic [7:0] M_CL  = 8'h40;

  typedef struct {
    int         at;
    logic [7:0] mask;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic sb_push(input int at, input logic [7:0] m, input logic [7:0] v, input string nm);
    exp_t e;
    int   idx;
    e.at = at; e.mask = m; e.val = v; e.name = nm;
    idx = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].at > at) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compares due snapshots and the no-overlap invariant every cycle.
  exp_t cur;
  always @(negedge clk) begin
    checks++;
    if ((gate_ah && gate_al) || (gate_bh && gate_bl) || (gate_ch && gate_cl)) begin
      errors++;
      $display("FAIL gate_overlap @cycle %0d: got %b, required no leg with both gates high", cyc, obs[5:0]);
    end
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      cur = sb.pop_front();
      checks++;
      if (cur.at < cyc) begin
        errors++;
        $display("FAIL %s: due cycle %0d not sampled (now %0d)", cur.name, cur.at, cyc);
      end else if ((obs & cur.mask) !== cur.val) begin
        errors++;
        $display("FAIL %s @cycle %0d: got %b, required %b (mask %b)",
                 cur.name, cyc, obs & cur.mask, cur.val, cur.mask);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  int t;

  initial begin
    reset = 1'b1; enable = 1'b0; new_cycle = 1'b0; triangle_count = 16'd100;
    duty_a = '0; duty_b = '0; duty_c = '0; duty_valid = 1'b0;
    fault = 1'b0; fault_clear = 1'b0;
    step(2);
    sb_push(cyc, M_ALL, 8'h00, "reset_state");
    sb_push(cyc + 1, M_ALL, 8'h00, "reset_state_held");

    // Release: legs must sit in DEAD for the dead time, then settle LOW (cmp = 0).
    step(1);
    reset = 1'b0; enable = 1'b1; t = cyc;
    sb_push(t + 1,  M_G, 8'h00, "post_reset_dead_first");
    sb_push(t + 79, M_G, 8'h00, "post_reset_dead_last");
    sb_push(t + 80, M_G, 8'h15, "post_reset_low");
    step(100);

    // a=4000, b=0, c=9000 (saturates to 8001), then valley load.
    t = cyc;
    duty_a = 16'd4000; duty_b = 16'd0; duty_c = 16'd9000; duty_valid = 1'b1;
    triangle_count = 16'd0;
    sb_push(t + 2,  M_CL, M_CL,  "load1_pulse");
    sb_push(t + 3,  M_CL, 8'h00, "load1_pulse_single");
    sb_push(t + 3,  M_G, 8'h15, "load1_before_commutate");
    sb_push(t + 4,  M_G, 8'h04, "load1_dead_first");
    sb_push(t + 83, M_G, 8'h04, "load1_dead_last");
    sb_push(t + 84, M_G, 8'h26, "load1_high");
    step(1); duty_valid = 1'b0; new_cycle = 1'b1;
    step(1); new_cycle = 1'b0;
    step(88);
    triangle_count = 16'd3999;
    sb_push(cyc + 5, M_G, 8'h26, "cmp_3999_still_high");
    step(10);

    // Carrier reaches 4000: A commutates to LOW through 80 dead cycles.
    t = cyc; triangle_count = 16'd4000;
    sb_push(t + 1,  M_G, 8'h26, "fall_before");
    sb_push(t + 2,  M_G, 8'h06, "fall_dead_first");
    sb_push(t + 81, M_G, 8'h06, "fall_dead_last");
    sb_push(t + 82, M_G, 8'h16, "fall_low");
    step(100);

    // Peak: C (8001) must stay high at 8000.
    t = cyc; triangle_count = 16'd8000;
    sb_push(t + 2, M_G, 8'h16, "peak_hold_2");
    sb_push(t + 5, M_G, 8'h16, "peak_hold_5");
    step(10);

    // Valley with reload from pending (no new duty).
    t = cyc; triangle_count = 16'd0; new_cycle = 1'b1;
    sb_push(t + 1,  M_CL, M_CL,  "load2_pulse");
    sb_push(t + 2,  M_CL, 8'h00, "load2_pulse_single");
    sb_push(t + 1,  M_G, 8'h16, "valley_before");
    sb_push(t + 2,  M_G, 8'h06, "rise_dead_first");
    sb_push(t + 81, M_G, 8'h06, "rise_dead_last");
    sb_push(t + 82, M_G, 8'h26, "rise_high");
    step(1); new_cycle = 1'b0;
    step(99);

    // Pending 6000 is superseded by a coincident strobe of 2000.
    duty_a = 16'd6000; duty_valid = 1'b1;
    step(1); duty_valid = 1'b0;
    step(4);
    t = cyc;
    duty_a = 16'd2000; duty_valid = 1'b1; new_cycle = 1'b1; triangle_count = 16'd3000;
    sb_push(t + 1,  M_CL, M_CL, "coincident_pulse");
    sb_push(t + 2,  M_G, 8'h26, "coincident_before");
    sb_push(t + 3,  M_G, 8'h06, "coincident_dead");
    sb_push(t + 82, M_G, 8'h06, "coincident_dead_last");
    sb_push(t + 83, M_G, 8'h16, "coincident_low");
    step(1); duty_valid = 1'b0; new_cycle = 1'b0;
    step(99);
    t = cyc; new_cycle = 1'b1;
    sb_push(t + 1, M_CL, M_CL, "reload_pulse");
    sb_push(t + 5, M_G, 8'h16, "reload_keeps_2000");
    step(1); new_cycle = 1'b0;
    step(19);

    // raw_a chatter every 30 cycles around cmp 2000.
    t = cyc; triangle_count = 16'd1999;
    sb_push(t + 1,   M_A, 8'h10, "chatter_before");
    sb_push(t + 2,   M_A, 8'h00, "chatter_dead");
    sb_push(t + 31,  M_A, 8'h00, "chatter_dead_31");
    sb_push(t + 61,  M_A, 8'h00, "chatter_dead_61");
    sb_push(t + 100, M_A, 8'h00, "chatter_dead_100");
    sb_push(t + 141, M_A, 8'h00, "chatter_dead_141");
    sb_push(t + 142, M_A, 8'h20, "chatter_settled_high");
    step(30); triangle_count = 16'd2000;
    step(30); triangle_count = 16'd1999;
    step(100);

    // One-cycle fault pulse, followed later by fault_clear.
    t = cyc; fault = 1'b1;
    sb_push(t + 1, M_ALL, 8'h80, "fault_trip");
`ifdef PWM_FAULT_LATCH_EN
    sb_push(t + 2,  M_ALL, 8'h80, "fault_latched");
    sb_push(t + 10, M_ALL, 8'h80, "fault_latched_10");
    sb_push(t + 11, M_ALL, 8'h00, "fault_cleared");
    sb_push(t + 90, M_G, 8'h00, "fault_dead_last");
    sb_push(t + 91, M_G, 8'h26, "fault_restored");
`else
    sb_push(t + 2,  M_ALL, 8'h00, "fault_follow");
    sb_push(t + 11, M_ALL, 8'h00, "fault_clear_ignored");
    sb_push(t + 81, M_G, 8'h00, "fault_dead_last");
    sb_push(t + 82, M_G, 8'h26, "fault_restored");
`endif
    sb_push(t + 99, M_G, 8'h26, "pre_reset_high");
    step(1); fault = 1'b0;
    step(9); fault_clear = 1'b1;
    step(1); fault_clear = 1'b0;
    step(89);

    // Asynchronous reset mid-HIGH: gates must drop before any further edge.
    t = cyc; reset = 1'b1;
    sb_push(t,     M_ALL, 8'h00, "async_reset_drop");
    sb_push(t + 2, M_ALL, 8'h00, "reset_held");
    step(3);
    t = cyc; reset = 1'b0;
    sb_push(t + 1,  M_G, 8'h00, "rerelease_dead_first");
    sb_push(t + 79, M_G, 8'h00, "rerelease_dead_last");
    sb_push(t + 80, M_G, 8'h15, "rerelease_low");
    step(100);

    // Disable: gates off, no load pulse, pending still captured.
    t = cyc; enable = 1'b0;
    sb_push(t + 1,  M_ALL, 8'h00, "disable_off");
    sb_push(t + 4,  M_ALL, 8'h00, "disable_no_load");
    sb_push(t + 11, M_CL, M_CL,  "enable_load_pulse");
    sb_push(t + 89, M_G, 8'h00, "enable_dead_last");
    sb_push(t + 90, M_G, 8'h04, "enable_b_low");
    sb_push(t + 92, M_G, 8'h04, "enable_a_c_dead");
    sb_push(t + 93, M_G, 8'h26, "enable_a_c_high");
    step(2);
    duty_a = 16'd5000; duty_b = 16'd0; duty_c = 16'd9000; duty_valid = 1'b1;
    step(1); duty_valid = 1'b0; new_cycle = 1'b1;
    step(1); new_cycle = 1'b0;
    step(6);
    enable = 1'b1; new_cycle = 1'b1; triangle_count = 16'd3000;
    step(1); new_cycle = 1'b0;
    step(95);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
